// File: rtl/nibble_accumulator_pkg.sv
// nibble_acc_pkg: opcodes, FSM states and constants shared by the nibble accumulator.
package nibble_acc_pkg;
    localparam int ACC_W = 4;
    localparam logic [ACC_W-1:0] SAT_POS = 4'b0111;
    localparam logic [ACC_W-1:0] SAT_NEG = 4'b1000;
    localparam logic [ACC_W-1:0] ONE = 4'b0001;
    typedef enum logic [1:0] {OP_CLR, OP_LOAD, OP_ADD, OP_SUB} op_e;
    typedef enum logic [1:0] {IDLE, EXEC, SUB2, RESP} state_e;
    function automatic logic [ACC_W-1:0] clamp(input logic neg);
        return neg ? SAT_NEG : SAT_POS;
    endfunction
endpackage

// File: rtl/nibble_accumulator_if.sv
// nibble_acc_if: command/response handshake of the nibble accumulator.
interface nibble_acc_if;
    import nibble_acc_pkg::*;
    logic in_valid;
    logic in_ready;
    op_e in_op;
    logic [ACC_W-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [ACC_W-1:0] out_acc;
    logic out_c;
    logic out_v;
    logic sticky_v;
    modport master (output in_valid, in_op, in_data, out_ready,
                    input in_ready, out_valid, out_acc, out_c, out_v, sticky_v);
    modport slave (input in_valid, in_op, in_data, out_ready,
                   output in_ready, out_valid, out_acc, out_c, out_v, sticky_v);
endinterface

// File: rtl/nibble_accumulator.sv
// nibble_accumulator: 4-bit signed accumulator driving an external ripple adder.
// Define NIBBLE_ACC_SATURATE_EN to clamp overflowing ADD/SUB results.
module nibble_accumulator
    import nibble_acc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    nibble_acc_if.slave      bus,
    output logic [ACC_W-1:0] adder_a,
    output logic [ACC_W-1:0] adder_b,
    input  logic [ACC_W-1:0] adder_s,
    input  logic             adder_cout,
    input  logic             adder_v
);
    state_e state_q, state_d;
    op_e op_q, op_d;
    logic [ACC_W-1:0] data_q, data_d, acc_q, acc_d, tmp_q, tmp_d, res_acc;
    logic c_q, c_d, v_q, v_d, sticky_q, sticky_d, c1_q, c1_d, sub_v, res_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q <= OP_CLR;
            data_q <= '0;
            acc_q <= '0;
            tmp_q <= '0;
            c_q <= 1'b0;
            v_q <= 1'b0;
            sticky_q <= 1'b0;
            c1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            data_q <= data_d;
            acc_q <= acc_d;
            tmp_q <= tmp_d;
            c_q <= c_d;
            v_q <= v_d;
            sticky_q <= sticky_d;
            c1_q <= c1_d;
        end
    end

    always_comb begin
        state_d = state_q == IDLE ? (bus.in_valid ? EXEC : IDLE) :
                  state_q == EXEC ? (op_q == OP_SUB ? SUB2 : RESP) :
                  state_q == SUB2 ? RESP :
                  (bus.out_ready ? IDLE : RESP);
    end

    always_comb begin
        bus.in_ready = state_q == IDLE;
        bus.out_valid = state_q == RESP;
        bus.out_acc = acc_q;
        bus.out_c = c_q;
        bus.out_v = v_q;
        bus.sticky_v = sticky_q;
        adder_a = state_q == EXEC ? acc_q : state_q == SUB2 ? tmp_q : '0;
        adder_b = state_q == EXEC ? (op_q == OP_SUB ? ~data_q : data_q) :
                  state_q == SUB2 ? ONE : '0;
    end

    // SUB overflow is judged against the original operands, not the two adder passes
    assign sub_v = (acc_q[3] != data_q[3]) && (adder_s[3] != acc_q[3]);
    assign res_v = state_q == SUB2 ? sub_v : adder_v;
`ifdef NIBBLE_ACC_SATURATE_EN
    assign res_acc = res_v ? clamp(acc_q[3]) : adder_s;
`else
    assign res_acc = adder_s;
`endif

    always_comb begin
        op_d = op_q;
        data_d = data_q;
        acc_d = acc_q;
        tmp_d = tmp_q;
        c_d = c_q;
        v_d = v_q;
        sticky_d = sticky_q;
        c1_d = c1_q;
        if (state_q == IDLE && bus.in_valid) begin
            op_d = bus.in_op;
            data_d = bus.in_data;
        end
        if (state_q == EXEC) begin
            case (op_q)
                OP_CLR: begin
                    acc_d = '0;
                    c_d = 1'b0;
                    v_d = 1'b0;
                    sticky_d = 1'b0;
                end
                OP_LOAD: begin
                    acc_d = data_q;
                    c_d = 1'b0;
                    v_d = 1'b0;
                end
                OP_ADD: begin
                    acc_d = res_acc;
                    c_d = adder_cout;
                    v_d = res_v;
                    sticky_d = sticky_q | res_v;
                end
                OP_SUB: begin
                    tmp_d = adder_s;
                    c1_d = adder_cout;
                end
            endcase
        end
        if (state_q == SUB2) begin
            acc_d = res_acc;
            c_d = c1_q | adder_cout;
            v_d = res_v;
            sticky_d = sticky_q | res_v;
        end
    end
endmodule

// File: tb/tb_nibble_accumulator.sv
// tb_nibble_accumulator: directed checks of nibble_accumulator with a behavioural 4-bit adder.
module tb_nibble_accumulator;
    import nibble_acc_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] adder_a, adder_b, adder_s;
    logic adder_cout, adder_v;
    logic [3:0] acc_m = 4'h0;
    int total = 0;
    int bad = 0;
`ifdef NIBBLE_ACC_SATURATE_EN
    localparam logic [3:0] OVF_ADD = 4'h7;
    localparam logic [3:0] OVF_SUB = 4'h8;
`else
    localparam logic [3:0] OVF_ADD = 4'h8;
    localparam logic [3:0] OVF_SUB = 4'h7;
`endif

    always #5 clk = ~clk;

    nibble_acc_if bus();

    assign {adder_cout, adder_s} = {1'b0, adder_a} + {1'b0, adder_b};
    assign adder_v = (adder_a[3] == adder_b[3]) && (adder_s[3] != adder_a[3]);

    nibble_accumulator dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave),
        .adder_a(adder_a),
        .adder_b(adder_b),
        .adder_s(adder_s),
        .adder_cout(adder_cout),
        .adder_v(adder_v)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input op_e op, input logic [3:0] d);
        @(negedge clk);
        chk("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_op = op;
        bus.in_data = d;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic run(input op_e op, input logic [3:0] d, input logic [3:0] ea,
                       input logic ec, input logic ev, input logic es);
        logic [3:0] nd;
        nd = ~d;
        send(op, d);
        @(negedge clk);
        chk("exec_valid", bus.out_valid, 0);
        chk("exec_ready", bus.in_ready, 0);
        if (op == OP_ADD || op == OP_SUB) begin
            chk("exec_a", adder_a, acc_m);
            chk("exec_b", adder_b, op == OP_SUB ? nd : d);
        end
        if (op == OP_SUB) begin
            @(negedge clk);
            chk("sub2_valid", bus.out_valid, 0);
            chk("sub2_b", adder_b, 4'h1);
        end
        @(negedge clk);
        chk("resp_valid", bus.out_valid, 1);
        chk("resp_acc", bus.out_acc, ea);
        chk("resp_c", bus.out_c, ec);
        chk("resp_v", bus.out_v, ev);
        chk("resp_sticky", bus.sticky_v, es);
        chk("resp_adder_a", adder_a, 0);
        chk("resp_adder_b", adder_b, 0);
        acc_m = ea;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_op = OP_CLR;
        bus.in_data = 4'h0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_acc", bus.out_acc, 0);
        chk("rst_c", bus.out_c, 0);
        chk("rst_v", bus.out_v, 0);
        chk("rst_sticky", bus.sticky_v, 0);
        chk("rst_adder_a", adder_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bus.in_ready, 1);

        run(OP_LOAD, 4'h3, 4'h3, 0, 0, 0);
        run(OP_ADD, 4'h4, 4'h7, 0, 0, 0);
        run(OP_LOAD, 4'h7, 4'h7, 0, 0, 0);
        run(OP_ADD, 4'h1, OVF_ADD, 0, 1, 1);
        run(OP_LOAD, 4'h5, 4'h5, 0, 0, 1);
        run(OP_SUB, 4'h3, 4'h2, 1, 0, 1);
        run(OP_LOAD, 4'h8, 4'h8, 0, 0, 1);
        run(OP_SUB, 4'h1, OVF_SUB, 1, 1, 1);
        run(OP_CLR, 4'h0, 4'h0, 0, 0, 0);
        run(OP_LOAD, 4'hF, 4'hF, 0, 0, 0);
        run(OP_ADD, 4'h2, 4'h1, 1, 0, 0);

        send(OP_LOAD, 4'h6);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_acc", bus.out_acc, 4'h6);
            chk("bp_ready", bus.in_ready, 0);
            bus.in_valid = i == 2;
            bus.in_op = OP_LOAD;
            bus.in_data = 4'h9;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        acc_m = 4'h6;
        run(OP_ADD, 4'h1, 4'h7, 0, 0, 0);

        run(OP_LOAD, 4'h7, 4'h7, 0, 0, 0);
        run(OP_ADD, 4'h1, OVF_ADD, 0, 1, 1);
        run(OP_LOAD, 4'h5, 4'h5, 0, 0, 1);
        send(OP_SUB, 4'h3);
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_sub2", adder_b, 4'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_acc", bus.out_acc, 0);
        chk("abort_c", bus.out_c, 0);
        chk("abort_v", bus.out_v, 0);
        chk("abort_sticky", bus.sticky_v, 0);
        chk("abort_adder_b", adder_b, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_valid_rst", bus.out_valid, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_valid_after", bus.out_valid, 0);
            chk("abort_ready_after", bus.in_ready, 1);
        end
        acc_m = 4'h0;
        run(OP_ADD, 4'h2, 4'h2, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
